// File: rtl/acumulador_pkg.sv
// Shared types and constants for the serial accumulator: FSM states, data word, saturation limits.
package acumulador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic signed [7:0] data_t;

  localparam data_t SAT_MAX = 8'sd127;
  localparam data_t SAT_MIN = -8'sd128;

  // On signed overflow both operands share a sign, so the operand's sign selects the rail.
  function automatic data_t saturate(input logic neg);
    return neg ? SAT_MIN : SAT_MAX;
  endfunction

endpackage

// File: rtl/acumulador_serial_if.sv
// Bundle of control, operand stream, adder and result signals of acumulador_serial.
// slave = the accumulator block, master = its environment (driver plus external adder).
interface acumulador_serial_if #(
  parameter int CNT_W = 8
);
  import acumulador_pkg::*;

  logic             start;
  logic [CNT_W-1:0] n_ops;
  logic             in_valid;
  logic             in_ready;
  data_t            in_data;
  data_t            add_a;
  data_t            add_b;
  data_t            add_s;
  logic             add_flag;
  data_t            acc;
  logic             ovf;
  logic             busy;
  logic             done;

  modport slave (
    input  start, n_ops, in_valid, in_data, add_s, add_flag,
    output in_ready, add_a, add_b, acc, ovf, busy, done
  );

  modport master (
    output start, n_ops, in_valid, in_data, add_s, add_flag,
    input  in_ready, add_a, add_b, acc, ovf, busy, done
  );

endinterface

// File: rtl/somador.sv
// 8-bit signed combinational adder with signed-overflow flag; sits downstream of acumulador_serial.
module somador (
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic signed [7:0] s,
  output logic              flag
);

  assign s    = a + b;
  assign flag = (a[7] == b[7]) && (s[7] != a[7]);

endmodule

// File: rtl/acumulador_serial.sv
// Serial signed-byte accumulator driving an external adder over a valid/ready stream.
// Define ACUMULADOR_SATURACAO_EN to saturate instead of wrapping on overflow.
module acumulador_serial
  import acumulador_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  acumulador_serial_if.slave  bus
);

  state_e           state_q, state_d;
  data_t            acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             in_ready, busy, done;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    rem_d    = rem_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.n_ops != '0) begin
            rem_d   = bus.n_ops;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end

      RUN: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (bus.in_valid) begin
`ifdef ACUMULADOR_SATURACAO_EN
          acc_d = bus.add_flag ? saturate(bus.in_data[7]) : bus.add_s;
`else
          acc_d = bus.add_s;
`endif
          ovf_d = ovf_q | bus.add_flag;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // The adder sees the live total and operand with no register in between.
  assign bus.add_a    = acc_q;
  assign bus.add_b    = bus.in_data;
  assign bus.acc      = acc_q;
  assign bus.ovf      = ovf_q;
  assign bus.in_ready = in_ready;
  assign bus.busy     = busy;
  assign bus.done     = done;

endmodule

// File: tb/tb_acumulador_serial.sv
// Self-checking bench for acumulador_serial wired to somador; honours ACUMULADOR_SATURACAO_EN.
module tb_acumulador_serial;
  import acumulador_pkg::*;

  localparam int CNT_W = 8;

  typedef struct {
    data_t acc;
    logic  ovf;
  } st_t;

  typedef struct {
    int    n;
    data_t ops[8];
    int    gap;
    data_t exp_acc;
    logic  exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;
  st_t  sb[$];

  acumulador_serial_if #(.CNT_W(CNT_W)) bus ();

  acumulador_serial #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  somador u_add (
    .a    (bus.add_a),
    .b    (bus.add_b),
    .s    (bus.add_s),
    .flag (bus.add_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic on plain integers.
  function automatic st_t model_step(input st_t s, input data_t op);
    st_t r;
    int  sum;
    sum   = int'(s.acc) + int'(op);
    r.ovf = s.ovf;
    r.acc = data_t'(sum);
    if (sum > 127 || sum < -128) begin
      r.ovf = 1'b1;
`ifdef ACUMULADOR_SATURACAO_EN
      r.acc = (sum > 127) ? data_t'(127) : data_t'(-128);
`endif
    end
    return r;
  endfunction

  function automatic vec_t mk(input int n, input int o0, input int o1, input int o2,
                              input int gap, input int ea, input logic eo);
    vec_t v;
    v.n = n;
    foreach (v.ops[i]) v.ops[i] = '0;
    v.ops[0]  = data_t'(o0);
    v.ops[1]  = data_t'(o1);
    v.ops[2]  = data_t'(o2);
    v.gap     = gap;
    v.exp_acc = data_t'(ea);
    v.exp_ovf = eo;
    return v;
  endfunction

  // Scoreboard consumer: one expected result per completed run.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      check("sb_depth_at_done", sb.size(), 1);
      if (sb.size() > 0) begin
        st_t e;
        e = sb.pop_front();
        check("final_acc", int'(bus.acc), int'(e.acc));
        check("final_ovf", int'(bus.ovf), int'(e.ovf));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    st_t m;
    st_t e;
    int  busy_cnt;
    m.acc    = '0;
    m.ovf    = 1'b0;
    busy_cnt = 0;
    e.acc    = v.exp_acc;
    e.ovf    = v.exp_ovf;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.n_ops = CNT_W'(v.n);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = v.ops[i];
      #1;
      check("in_ready_run", int'(bus.in_ready), 1);
      busy_cnt += int'(bus.busy);
      tick();
      bus.in_valid = 1'b0;
      m = model_step(m, v.ops[i]);
      check("acc_step", int'(bus.acc), int'(m.acc));
      if (i < v.n - 1) begin
        for (int g = 0; g < v.gap; g++) begin
          busy_cnt += int'(bus.busy);
          tick();
          check("acc_hold_gap", int'(bus.acc), int'(m.acc));
        end
      end
    end
    check("done_pulse", int'(bus.done), 1);
    check("busy_in_done", int'(bus.busy), 0);
    check("in_ready_in_done", int'(bus.in_ready), 0);
    check("busy_cycles", busy_cnt, v.n + v.gap * ((v.n > 0) ? v.n - 1 : 0));
    tick();
    check("done_one_cycle", int'(bus.done), 0);
    check("acc_held_idle", int'(bus.acc), int'(v.exp_acc));
    check("in_ready_idle", int'(bus.in_ready), 0);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t rv;
    st_t  m;
    st_t  e;

    vecs[0] = mk(3, 5, -2, 10, 0, 13, 1'b0);
`ifdef ACUMULADOR_SATURACAO_EN
    vecs[1] = mk(2, 127, 7, 0, 0, 127, 1'b1);
    vecs[2] = mk(2, -128, -2, 0, 0, -128, 1'b1);
    vecs[3] = mk(3, 127, 1, -1, 2, 126, 1'b1);
`else
    vecs[1] = mk(2, 127, 1, 0, 0, -128, 1'b1);
    vecs[2] = mk(2, -128, -2, 0, 0, 126, 1'b1);
    vecs[3] = mk(3, 127, 1, -1, 2, 127, 1'b1);
`endif
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 1'b0);

    bus.start    = 1'b0;
    bus.n_ops    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    #12;
    check("rst_acc", int'(bus.acc), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // start and a new n_ops during RUN must not restart or resize the run.
    e.acc = data_t'(45);
    e.ovf = 1'b0;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.n_ops = CNT_W'(3);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data_t'(20);
    tick();
    bus.in_data = data_t'(30);
    bus.start   = 1'b1;
    bus.n_ops   = CNT_W'(1);
    tick();
    bus.start = 1'b0;
    check("start_ignored_busy", int'(bus.busy), 1);
    check("start_ignored_done", int'(bus.done), 0);
    check("start_ignored_acc", int'(bus.acc), 50);
    bus.in_data = data_t'(-5);
    tick();
    bus.in_valid = 1'b0;
    check("start_ignored_end", int'(bus.done), 1);
    tick();

    // Asynchronous reset between edges after 1 of 4 operands.
    bus.start = 1'b1;
    bus.n_ops = CNT_W'(4);
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = data_t'(10);
    tick();
    bus.in_valid = 1'b0;
    check("pre_reset_acc", int'(bus.acc), 10);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_acc", int'(bus.acc), 0);
    check("midrst_ovf", int'(bus.ovf), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle_busy", int'(bus.busy), 0);
    run_vec(mk(1, -5, 0, 0, 0, -5, 1'b0));

    // Random runs scored against the integer model.
    for (int r = 0; r < 6; r++) begin
      rv     = mk(0, 0, 0, 0, 0, 0, 1'b0);
      rv.n   = int'($urandom_range(1, 6));
      rv.gap = int'($urandom_range(0, 1));
      m.acc  = '0;
      m.ovf  = 1'b0;
      for (int i = 0; i < rv.n; i++) begin
        rv.ops[i] = data_t'($urandom_range(0, 255));
        m = model_step(m, rv.ops[i]);
      end
      rv.exp_acc = m.acc;
      rv.exp_ovf = m.ovf;
      run_vec(rv);
    end

    tick();
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/acumulador_serial.md
Name: acumulador_serial

Overview:
- Sequential stage that sits directly upstream of the 8-bit signed adder (somador).
- Accepts a stream of signed bytes over a valid/ready handshake and drives the adder inputs (a = running total, b = incoming operand).
- Captures the adder's sum (s) and overflow (flag) back into its accumulator.
- Reports the final total, a sticky overflow indication and a one-cycle done pulse after a programmed number of operands.

Parameters:
- CNT_W, 8, width of the operand-count register (max 2^CNT_W-1 operands per run)

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE
- n_ops  input  CNT_W  number of operands for the run; sampled with start
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  8  signed operand (two's complement)
- add_a  output  8  to adder input a; always equals acc
- add_b  output  8  to adder input b; always equals in_data
- add_s  input  8  adder sum (combinational from add_a/add_b)
- add_flag  input  1  adder signed-overflow flag
- acc  output  8  running/final total (signed)
- ovf  output  1  sticky overflow for the current run
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at end of run

Interface decisions:
- One clock (clk).
- Reset rst is asynchronous and active-high.

Behaviour:
- Reset values:
  - State returns to IDLE.
  - acc=0, ovf=0, remaining=0.
  - busy=0, done=0, in_ready=0.
- States:
  - IDLE:
    - in_ready=0.
    - On start=1 with n_ops>0: acc<=0, ovf<=0, remaining<=n_ops, go to RUN.
    - On start=1 with n_ops=0: acc<=0, ovf<=0, go to DONE (zero-length run).
  - RUN:
    - busy=1, in_ready=1.
    - On in_valid (a transfer): acc<=add_s, ovf<=ovf|add_flag, remaining<=remaining-1.
    - If remaining==1 on that transfer, go to DONE.
    - No transfer: all registers hold.
  - DONE:
    - done=1 for exactly one cycle, busy=0, in_ready=0, then go to IDLE.
    - acc and ovf remain held until the next accepted start.
- Latency: each operand is accumulated 1 cycle after its transfer, giving a throughput of 1 operand per cycle.
  - done asserts the cycle after the last transfer; acc is already final in that cycle.
- Arithmetic:
  - 8-bit two's complement; wrap-around on overflow (e.g. 127+1 -> -128, ovf=1).
  - ovf is sticky: once set it stays set even if later operands bring the total back in range.
- start while busy or in DONE is ignored.
- n_ops changes mid-run have no effect.
- rst asserted mid-run aborts immediately to the reset values; a partial total is discarded.
- add_a and add_b are purely combinational copies; the block adds no register between itself and the adder.

Optional Feature:
- Macro: ACUMULADOR_SATURACAO_EN.
- Defined: on a transfer with add_flag=1, acc saturates instead of wrapping.
  - acc <= 8'sd127 if in_data[7]==0.
  - acc <= -8'sd128 if in_data[7]==1. Signed overflow implies both operands share a sign.
  - ovf is still set.
- Undefined: wrap-around as above.

Decomposition:
- Shared package acumulador_pkg:
  - state enum (IDLE, RUN, DONE).
  - constants SAT_MAX=8'sd127 and SAT_MIN=-8'sd128.
  - typedef for the signed 8-bit data word.
- No sub-module inside the block.
- The testbench instantiates acumulador_serial alongside somador, connecting add_a/add_b/add_s/add_flag.

Test Plan:
- Basic run: start, n_ops=3, stream 5, -2, 10 back-to-back -> acc=13, ovf=0; done pulses 1 cycle after the 3rd transfer; busy high for exactly 3 cycles.
- Overflow wrap (macro undefined): n_ops=2, stream 127, 1 -> acc=-128, ovf=1.
- Overflow saturation (macro defined): n_ops=2, stream 127, 7 -> acc=127, ovf=1; n_ops=2, stream -128, -2 -> acc=-128, ovf=1.
- Sticky overflow and handshake gaps: n_ops=3, stream 127, 1, -1 with in_valid low for 2 cycles between operands -> acc=127 (wrap mode), ovf=1; acc holds during gaps.
- Edge cases:
  - n_ops=0 -> done the next cycle, acc=0, in_ready never high.
  - start pulsed during RUN -> ignored; the count is unchanged.
- Reset mid-run: rst asserted asynchronously (between clock edges) after 1 of 4 operands -> acc=0, ovf=0, busy=0 immediately; a following run with n_ops=1 and operand -5 -> acc=-5.
